// File: rtl/replica_pkg.sv
// Shared types and constants for the on-chip host-bus sequencer.
// Command/response bundles, AXI response codes and register map.
package replica_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 64;
    localparam int BUS_STRB_W = BUS_DATA_W / 8;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Accelerator register map as seen from the sequencer
    localparam logic [BUS_ADDR_W-1:0] REG_SEED  = 32'h0000_0010;
    localparam logic [BUS_ADDR_W-1:0] REG_DIST  = 32'h0000_0018;
    localparam logic [BUS_ADDR_W-1:0] REG_ORDER = 32'h0000_0020;
    localparam logic [BUS_ADDR_W-1:0] REG_RUN   = 32'h0000_0028;

    typedef struct packed {
        logic                  write;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [BUS_STRB_W-1:0] wstrb;
    } bus_cmd_t;

    typedef struct packed {
        logic                  write;
        logic [BUS_DATA_W-1:0] rdata;
        logic [1:0]            resp;
    } bus_rsp_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WB,
        S_RA,
        S_RD,
        S_RSP
    } state_t;

endpackage

// File: rtl/axi_cmd_master.sv
// AXI4-Lite initiator: one single-beat command in flight, strictly in order.
// Define BUS_MASTER_TIMEOUT_EN to enable the sticky watchdog flag.
module axi_cmd_master
    import replica_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic                  busy,
    output logic                  timeout,

    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    if (ADDR_W != BUS_ADDR_W || DATA_W != BUS_DATA_W
        || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("axi_cmd_master: unsupported parameter set");
    end

    state_t   state;
    bus_cmd_t cmd_q;
    bus_rsp_t rsp_q;

    // Held low through reset so nothing is accepted before the slave is up
    assign cmd_ready = (state == S_IDLE) && M_AXI_ARESETN;
    assign busy      = (state != S_IDLE);

    assign M_AXI_AWADDR = cmd_q.addr;
    assign M_AXI_ARADDR = cmd_q.addr;
    assign M_AXI_WDATA  = cmd_q.wdata;
    assign M_AXI_WSTRB  = cmd_q.wstrb;

    assign rsp_write = rsp_q.write;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_resp  = rsp_q.resp;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= S_IDLE;
            cmd_q         <= '0;
            rsp_q         <= '0;
            rsp_valid     <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q <= '{write: cmd_write,
                                   addr:  cmd_addr,
                                   wdata: cmd_wdata,
                                   wstrb: cmd_wstrb};
                        if (cmd_write) begin
                            state         <= S_WR;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                        end else begin
                            state         <= S_RA;
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    // Each channel is done once its VALID has dropped or handshakes now
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY)
                        && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                        state        <= S_WB;
                        M_AXI_BREADY <= 1'b1;
                    end
                end
                S_WB: begin
                    if (M_AXI_BVALID) begin
                        rsp_q <= '{write: 1'b1,
                                   rdata: '0,
                                   resp:  M_AXI_BRESP};
                        M_AXI_BREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= S_RSP;
                    end
                end
                S_RA: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= S_RD;
                    end
                end
                S_RD: begin
                    if (M_AXI_RVALID) begin
                        rsp_q <= '{write: 1'b0,
                                   rdata: M_AXI_RDATA,
                                   resp:  M_AXI_RRESP};
                        M_AXI_RREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W-1:0] to_nxt;
    logic             accept;
    logic             waiting;

    assign accept  = cmd_valid && cmd_ready;
    assign waiting = (state == S_WR) || (state == S_WB)
                  || (state == S_RA) || (state == S_RD);
    assign to_nxt  = to_cnt + 1'b1;

    // Flag only; the transaction keeps waiting on the slave
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else if (accept) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else if (waiting && !timeout) begin
            to_cnt <= to_nxt;
            if (to_nxt == TO_LAST) timeout <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_cmd_master.sv
// Directed and random checks of axi_cmd_master against a behavioural slave.
// Build with BUS_MASTER_TIMEOUT_EN to also check the watchdog flag.
module tb_axi_cmd_master;
    import replica_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [7:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy, timeout;
    logic [31:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    axi_cmd_master #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYCLES(8)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .busy(busy), .timeout(timeout),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata),
        .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata),
        .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Slave configuration, written by the stimulus
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [63:0] cfg_rdata;
    logic [31:0] cur_addr;
    logic [63:0] cur_wdata;
    logic [7:0]  cur_wstrb;

    // Observations, written only by the slave/monitor process
    int cyc = 0;
    int n_acc = 0, n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    int t_acc = 0, t_first_v = -1, t_rspv = -1, t_to = -1;
    int t_aw_hs = 0, t_w_hs = 0;
    int awv_cycles = 0, wv_cycles = 0, arv_cycles = 0;
    int unstable = 0;
    logic [31:0] cap_awaddr, cap_araddr;
    logic [63:0] cap_wdata;
    logic [7:0]  cap_wstrb;
    bit got_aw, got_w, got_ar, bhs, rhs;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;

    initial begin : slave_mon
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        got_aw = 0; got_w = 0; got_ar = 0; bhs = 0; rhs = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                if (cmd_valid && cmd_ready) begin
                    n_acc++; t_acc = cyc; t_first_v = -1; t_rspv = -1;
                    t_to = -1; awv_cycles = 0; wv_cycles = 0; arv_cycles = 0;
                end
                if (t_first_v < 0 && ((awvalid && wvalid) || arvalid))
                    t_first_v = cyc;
                if (t_rspv < 0 && rsp_valid) t_rspv = cyc;
                if (t_to < 0 && timeout) t_to = cyc;
                if (awvalid) begin
                    awv_cycles++;
                    if (awaddr !== cur_addr) unstable++;
                end
                if (wvalid) begin
                    wv_cycles++;
                    if (wdata !== cur_wdata || wstrb !== cur_wstrb) unstable++;
                end
                if (arvalid) begin
                    arv_cycles++;
                    if (araddr !== cur_addr) unstable++;
                end
                if (awvalid && awready) begin
                    n_aw++; t_aw_hs = cyc; cap_awaddr = awaddr; got_aw = 1;
                end
                if (wvalid && wready) begin
                    n_w++; t_w_hs = cyc; cap_wdata = wdata;
                    cap_wstrb = wstrb; got_w = 1;
                end
                if (bvalid && bready) begin n_b++; bhs = 1; end
                if (arvalid && arready) begin
                    n_ar++; cap_araddr = araddr; got_ar = 1;
                end
                if (rvalid && rready) begin n_r++; rhs = 1; end
            end
            cyc++;
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                got_aw = 0; got_w = 0; got_ar = 0; bhs = 0; rhs = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            end else begin
                if (bhs) begin
                    bvalid = 0; bhs = 0; got_aw = 0; got_w = 0; b_wait = 0;
                end
                if (rhs) begin rvalid = 0; rhs = 0; got_ar = 0; r_wait = 0; end
                awready = 0;
                if (awvalid && !got_aw) begin
                    if (aw_wait >= aw_dly) awready = 1; else aw_wait++;
                end else aw_wait = 0;
                wready = 0;
                if (wvalid && !got_w) begin
                    if (w_wait >= w_dly) wready = 1; else w_wait++;
                end else w_wait = 0;
                arready = 0;
                if (arvalid && !got_ar) begin
                    if (ar_wait >= ar_dly) arready = 1; else ar_wait++;
                end else ar_wait = 0;
                if (got_aw && got_w && !bvalid) begin
                    if (b_wait >= b_dly) begin bvalid = 1; bresp = cfg_bresp; end
                    else b_wait++;
                end
                if (got_ar && !rvalid) begin
                    if (r_wait >= r_dly) begin
                        rvalid = 1; rresp = cfg_rresp; rdata = cfg_rdata;
                    end else r_wait++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference rule: writes report BRESP with zero data, reads report RDATA/RRESP
    function automatic bus_rsp_t model(input bit wr, input logic [63:0] rd,
                                       input logic [1:0] br, input logic [1:0] rr);
        bus_rsp_t r;
        r.write = wr;
        r.rdata = wr ? 64'h0 : rd;
        r.resp  = wr ? br : rr;
        return r;
    endfunction

    task automatic set_slave(input int a, input int w, input int b,
                             input int ar, input int r);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    task automatic issue(input bit wr, input logic [31:0] a,
                         input logic [63:0] d, input logic [7:0] s,
                         input string tag);
        int na;
        int n;
        cur_addr = a; cur_wdata = d; cur_wstrb = s;
        na = n_acc;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a;
        cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (n_acc == na && n < 50) begin @(posedge clk); #1; n++; end
        cmd_valid = 0;
        chk({tag, "_accept"}, 64'(n_acc - na), 64'd1);
    endtask

    task automatic finish_cmd(input bit wr, input logic [63:0] rd,
                              input logic [1:0] br, input logic [1:0] rr,
                              input int hold, input string tag);
        bus_rsp_t e;
        int n;
        e = model(wr, rd, br, rr);
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        for (int i = 0; i <= hold; i++) begin
            chk({tag, "_rsp_write"}, 64'(rsp_write), 64'(e.write));
            chk({tag, "_rsp_rdata"}, rsp_rdata, e.rdata);
            chk({tag, "_rsp_resp"}, 64'(rsp_resp), 64'(e.resp));
            chk({tag, "_cmd_ready_busy"}, 64'(cmd_ready), 64'd0);
            if (i < hold) @(negedge clk);
        end
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        chk({tag, "_cmd_ready_after"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_rsp_valid_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin : stim
        int nb0, nr0;
        logic [63:0] rd;
        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
        cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        cur_addr = 0; cur_wdata = 0; cur_wstrb = 0;
        set_slave(0, 0, 0, 0, 0);
        cfg_bresp = AXI_RESP_OKAY; cfg_rresp = AXI_RESP_OKAY; cfg_rdata = 0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_valids", 64'({awvalid, wvalid, arvalid}), 64'd0);
        chk("rst_readies", 64'({bready, rready}), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_resp}), 64'd0);
        chk("rst_rdata", rsp_rdata, 64'd0);
        chk("rst_busy_to", 64'({busy, timeout}), 64'd0);
        rst_n = 1;
        #1 chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // zero-wait write with latency checks
        nb0 = n_b;
        issue(1, REG_SEED, 64'h0123_4567_89AB_CDEF, 8'hFF, "t1");
        finish_cmd(1, 64'h0, AXI_RESP_OKAY, AXI_RESP_OKAY, 0, "t1");
        chk("t1_valid_lat", 64'(t_first_v - t_acc), 64'd1);
        chk("t1_rsp_lat", 64'(t_rspv - t_acc), 64'd3);
        chk("t1_awaddr", 64'(cap_awaddr), 64'h10);
        chk("t1_wdata", cap_wdata, 64'h0123_4567_89AB_CDEF);
        chk("t1_wstrb", 64'(cap_wstrb), 64'hFF);
        chk("t1_one_b", 64'(n_b - nb0), 64'd1);

        // read with ARREADY held off
        set_slave(0, 0, 0, 4, 0);
        cfg_rdata = 64'hDEAD_BEEF_0000_0001;
        issue(0, REG_ORDER, 64'h5555_5555_5555_5555, 8'h0F, "t2");
        finish_cmd(0, 64'hDEAD_BEEF_0000_0001, 2'b00, AXI_RESP_OKAY, 0, "t2");
        chk("t2_arvalid_cycles", 64'(arv_cycles), 64'd5);
        chk("t2_araddr", 64'(cap_araddr), 64'h20);
        chk("t2_stable", 64'(unstable), 64'd0);

        // W before AW, then AW before W
        set_slave(3, 0, 0, 0, 0);
        nb0 = n_b;
        issue(1, REG_DIST, 64'hA5A5_0000_FFFF_1234, 8'h3C, "t3a");
        finish_cmd(1, 64'h0, AXI_RESP_OKAY, 2'b00, 0, "t3a");
        chk("t3a_order", 64'(t_aw_hs - t_w_hs), 64'd3);
        chk("t3a_vcycles", 64'({awv_cycles[7:0], wv_cycles[7:0]}), 64'h0401);
        chk("t3a_one_b", 64'(n_b - nb0), 64'd1);
        set_slave(0, 3, 0, 0, 0);
        nb0 = n_b;
        issue(1, REG_RUN, 64'h0000_0000_0000_0001, 8'h01, "t3b");
        finish_cmd(1, 64'h0, AXI_RESP_OKAY, 2'b00, 0, "t3b");
        chk("t3b_order", 64'(t_w_hs - t_aw_hs), 64'd3);
        chk("t3b_vcycles", 64'({awv_cycles[7:0], wv_cycles[7:0]}), 64'h0104);
        chk("t3b_one_b", 64'(n_b - nb0), 64'd1);

        // SLVERR read with a stalled response consumer
        set_slave(0, 0, 0, 0, 0);
        cfg_rresp = AXI_RESP_SLVERR;
        cfg_rdata = 64'h1122_3344_5566_7788;
        issue(0, 32'h0000_0040, 64'h0, 8'h00, "t4");
        finish_cmd(0, 64'h1122_3344_5566_7788, 2'b00, AXI_RESP_SLVERR, 4, "t4");

        // reset pulse while waiting for B
        set_slave(0, 0, 10, 0, 0);
        cfg_bresp = AXI_RESP_OKAY;
        issue(1, REG_SEED, 64'hFEED_FACE_CAFE_BEEF, 8'hFF, "t5");
        nb0 = 0;
        while (!bready && nb0 < 50) begin @(negedge clk); nb0++; end
        chk("t5_in_wb", 64'(bready), 64'd1);
        #2 rst_n = 0;
        #1;
        chk("t5_rst_bready", 64'(bready), 64'd0);
        chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        set_slave(0, 0, 0, 0, 0);
        cfg_bresp = AXI_RESP_DECERR;
        nb0 = n_b;
        issue(1, REG_DIST, 64'h0000_0000_0000_0042, 8'hFF, "t5n");
        finish_cmd(1, 64'h0, AXI_RESP_DECERR, 2'b00, 0, "t5n");
        chk("t5n_one_b", 64'(n_b - nb0), 64'd1);

        // long BVALID stall: watchdog flag when built in, never otherwise
        set_slave(0, 0, 20, 0, 0);
        cfg_bresp = AXI_RESP_OKAY;
        issue(1, REG_RUN, 64'h1, 8'hFF, "t6");
        finish_cmd(1, 64'h0, AXI_RESP_OKAY, 2'b00, 0, "t6");
`ifdef BUS_MASTER_TIMEOUT_EN
        chk("t6_to_cycle", 64'(t_to - t_acc), 64'd8);
        chk("t6_to_sticky", 64'(timeout), 64'd1);
`else
        chk("t6_to_seen", 64'(t_to >= 0), 64'd0);
        chk("t6_to_flag", 64'(timeout), 64'd0);
`endif
        set_slave(0, 0, 0, 0, 0);
        issue(0, REG_SEED, 64'h0, 8'h0, "t6n");
        chk("t6n_to_cleared", 64'(timeout), 64'd0);
        finish_cmd(0, cfg_rdata, 2'b00, cfg_rresp, 0, "t6n");

        // random commands against the reference rule
        for (int k = 0; k < 24; k++) begin
            bit          wr;
            logic [31:0] a;
            logic [63:0] d;
            logic [7:0]  s;
            int          h;
            wr = 1'($urandom);
            a  = $urandom;
            d  = {$urandom, $urandom};
            s  = 8'($urandom);
            h  = $urandom_range(0, 2);
            set_slave($urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3));
            cfg_bresp = 2'($urandom);
            cfg_rresp = 2'($urandom);
            rd = {$urandom, $urandom};
            cfg_rdata = rd;
            nb0 = n_b; nr0 = n_r;
            issue(wr, a, d, s, "rnd");
            finish_cmd(wr, rd, cfg_bresp, cfg_rresp, h, "rnd");
            if (wr) begin
                chk("rnd_awaddr", 64'(cap_awaddr), 64'(a));
                chk("rnd_wdata", cap_wdata, d);
                chk("rnd_wstrb", 64'(cap_wstrb), 64'(s));
            end else begin
                chk("rnd_araddr", 64'(cap_araddr), 64'(a));
            end
            chk("rnd_b_count", 64'(n_b - nb0), 64'(wr));
            chk("rnd_r_count", 64'(n_r - nr0), 64'(!wr));
        end
        chk("final_stable", 64'(unstable), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
